// File: rtl/imm_packer.sv
// Purpose: RISC-V immediate encoder; scatters a signed immediate into I/S/B/J/U instruction fields and flags range/alignment/type errors.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle throughput. Optional clamp via IMM_PACKER_SAT_EN.
// Backpressure: valid/ready both sides; out_ready propagates combinationally to in_ready; words never dropped or reordered.
module imm_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_src,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: captured input word
    logic        s1_valid;
    logic [31:0] s1_imm;
    logic [2:0]  s1_src;
    logic [31:0] s1_base;

    // Stage 2: encoded word driving the outputs
    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;

    logic s2_adv;
    logic s1_adv;
    logic in_hs;
    logic out_hs;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = s2_valid && out_ready;

    // Range checks: the bits above the field's sign bit must all equal the sign
    logic rng_bad_is;
    logic rng_bad_b;
    logic rng_bad_j;

    assign rng_bad_is = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
    assign rng_bad_b  = !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
    assign rng_bad_j  = !((&s1_imm[31:20]) || !(|s1_imm[31:20]));

    // Immediate actually packed: either clamped to the format limits or passed through for truncation
    logic [31:0] imm_eff;

`ifdef IMM_PACKER_SAT_EN
    // Clamp out-of-range values toward the nearest representable (aligned) limit
    always_comb begin
        imm_eff = s1_imm;
        case (s1_src)
            SRC_I, SRC_S: if (rng_bad_is) imm_eff = s1_imm[31] ? 32'hFFFF_F800 : 32'h0000_07FF;
            SRC_B:        if (rng_bad_b)  imm_eff = s1_imm[31] ? 32'hFFFF_F000 : 32'h0000_0FFE;
            SRC_J:        if (rng_bad_j)  imm_eff = s1_imm[31] ? 32'hFFF0_0000 : 32'h000F_FFFE;
            default:      imm_eff = s1_imm;
        endcase
    end
`else
    assign imm_eff = s1_imm;
`endif

    // Scatter the immediate into the base word and derive the error flag
    logic [31:0] enc_instr;
    logic        enc_err;

    always_comb begin
        enc_instr = s1_base;
        enc_err   = 1'b0;
        case (s1_src)
            SRC_I: begin
                enc_instr[31:20] = imm_eff[11:0];
                enc_err          = rng_bad_is;
            end
            SRC_S: begin
                enc_instr[31:25] = imm_eff[11:5];
                enc_instr[11:7]  = imm_eff[4:0];
                enc_err          = rng_bad_is;
            end
            SRC_B: begin
                enc_instr[31]    = imm_eff[12];
                enc_instr[7]     = imm_eff[11];
                enc_instr[30:25] = imm_eff[10:5];
                enc_instr[11:8]  = imm_eff[4:1];
                enc_err          = rng_bad_b || s1_imm[0];
            end
            SRC_J: begin
                enc_instr[31]    = imm_eff[20];
                enc_instr[19:12] = imm_eff[19:12];
                enc_instr[20]    = imm_eff[11];
                enc_instr[30:21] = imm_eff[10:1];
                enc_err          = rng_bad_j || s1_imm[0];
            end
            SRC_U: begin
                enc_instr[31:12] = imm_eff[31:12];
                enc_err          = |s1_imm[11:0];
            end
            default: begin
                enc_instr = s1_base;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Stage 1 register: load on input handshake, empty when the word moves on
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= '0;
            s1_base  <= '0;
        end else begin
            if (in_hs) begin
                s1_valid <= 1'b1;
                s1_imm   <= in_imm;
                s1_src   <= in_src;
                s1_base  <= in_base;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register: take the encoded word when free or draining, otherwise hold it stable
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= enc_instr;
                s2_err   <= enc_err;
            end
        end
    end

    // Saturating counters of output handshakes and errored output handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_hs) begin
            if (enc_count != CNT_MAX) enc_count <= enc_count + CNT_ONE;
            if (s2_err && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;

endmodule

// File: tb/tb_imm_packer.sv
// Purpose: directed self-checking bench for imm_packer (encoding, errors, latency, backpressure, reset, saturation).
// Latency: drives after the rising edge, samples 1ns after the rising edge.
// Backpressure: exercises out_ready stalls and checks in_ready/ordering/stability.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_src = '0;
    logic [31:0] in_base = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_instr;
    logic        sat_out_err;
    logic [3:0]  sat_enc_count;
    logic [3:0]  sat_err_count;

    int errors = 0;
    int checks = 0;

    imm_packer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly
    imm_packer #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_instr(sat_out_instr), .out_err(sat_out_err),
        .enc_count(sat_enc_count), .err_count(sat_err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Push one word into an empty pipeline and wait for it at the output (out_ready held high)
    task automatic run_word(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                            output logic [31:0] instr, output logic err, output int lat);
        step();
        in_valid = 1'b1;
        in_src = src;
        in_imm = imm;
        in_base = base;
        out_ready = 1'b1;
        lat = 0;
        #1;
        while (!in_ready && lat < 20) begin
            step();
            lat++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        instr = out_instr;
        err = out_err;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err); end
        checks++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin
            errors++; $display("FAIL reset_counts: got %h/%h want 0000/0000", enc_count, err_count);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_encode();
        logic [31:0] instr;
        logic        err;
        int          lat;
        logic [31:0] exp_sat_i;
        do_reset();

        run_word(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, instr, err, lat);
        checks++; if (instr !== 32'hFFF0_0013 || err !== 1'b0) begin
            errors++; $display("FAIL enc_i_neg1: got %h/%b want fff00013/0", instr, err);
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL latency: got %0d want 2", lat); end

        run_word(3'b010, 32'h0000_0800, 32'h0000_0063, instr, err, lat);
        checks++; if (instr !== 32'h0000_00E3 || err !== 1'b0) begin
            errors++; $display("FAIL enc_b_800: got %h/%b want 000000e3/0", instr, err);
        end

        run_word(3'b011, 32'h0000_0001, 32'h0000_006F, instr, err, lat);
        checks++; if (instr !== 32'h0000_006F || err !== 1'b1) begin
            errors++; $display("FAIL enc_j_misalign: got %h/%b want 0000006f/1", instr, err);
        end
        step();
        checks++; if (enc_count !== 16'd3 || err_count !== 16'd1) begin
            errors++; $display("FAIL counts_after_j: got %0d/%0d want 3/1", enc_count, err_count);
        end

`ifdef IMM_PACKER_SAT_EN
        exp_sat_i = 32'h7FF0_0013;
`else
        exp_sat_i = 32'h8000_0013;
`endif
        run_word(3'b000, 32'h0000_0800, 32'h0000_0013, instr, err, lat);
        checks++; if (instr !== exp_sat_i || err !== 1'b1) begin
            errors++; $display("FAIL enc_i_range: got %h/%b want %h/1", instr, err, exp_sat_i);
        end

        run_word(3'b100, 32'h1234_5000, 32'h0000_0537, instr, err, lat);
        checks++; if (instr !== 32'h1234_5537 || err !== 1'b0) begin
            errors++; $display("FAIL enc_u_ok: got %h/%b want 12345537/0", instr, err);
        end

        run_word(3'b100, 32'h1234_5001, 32'h0000_0537, instr, err, lat);
        checks++; if (instr !== 32'h1234_5537 || err !== 1'b1) begin
            errors++; $display("FAIL enc_u_low: got %h/%b want 12345537/1", instr, err);
        end

        run_word(3'b111, 32'h0000_0004, 32'hDEAD_BEEF, instr, err, lat);
        checks++; if (instr !== 32'hDEAD_BEEF || err !== 1'b1) begin
            errors++; $display("FAIL enc_bad_src: got %h/%b want deadbeef/1", instr, err);
        end

        run_word(3'b001, 32'hFFFF_F805, 32'h0000_2023, instr, err, lat);
        checks++; if (instr !== 32'h8000_22A3 || err !== 1'b0) begin
            errors++; $display("FAIL enc_s_neg: got %h/%b want 800022a3/0", instr, err);
        end

        run_word(3'b011, 32'h000F_FFFE, 32'h0000_006F, instr, err, lat);
        checks++; if (instr !== 32'h7FFF_F06F || err !== 1'b0) begin
            errors++; $display("FAIL enc_j_max: got %h/%b want 7ffff06f/0", instr, err);
        end

        run_word(3'b010, 32'hFFFF_F000, 32'h0000_0063, instr, err, lat);
        checks++; if (instr !== 32'h8000_0063 || err !== 1'b0) begin
            errors++; $display("FAIL enc_b_min: got %h/%b want 80000063/0", instr, err);
        end
        step();
    endtask

    task automatic test_backpressure();
        int tx = 0;
        int rx = 0;
        logic [31:0] imm_k;
        logic [31:0] exp_k;
        do_reset();
        step();
        for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
            imm_k = 32'(10 * (tx + 1));
            in_valid = (tx < 5);
            in_src = 3'b000;
            in_imm = imm_k;
            in_base = 32'h0000_0013;
            out_ready = !(cyc >= 1 && cyc <= 3);
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++; if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready);
                end
            end
            if (out_valid) begin
                exp_k = (32'(10 * (rx + 1)) << 20) | 32'h0000_0013;
                checks++; if (out_instr !== exp_k || out_err !== 1'b0) begin
                    errors++; $display("FAIL bp_word%0d cyc%0d: got %h/%b want %h/0", rx, cyc, out_instr, out_err, exp_k);
                end
            end
            if (out_valid && out_ready) rx++;
            if (in_valid && in_ready) tx++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (rx != 5) begin errors++; $display("FAIL bp_drain: got %0d words want 5", rx); end
        checks++; if (enc_count !== 16'd5) begin errors++; $display("FAIL bp_enc_count: got %0d want 5", enc_count); end
    endtask

    task automatic test_midstream_reset();
        logic seen;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_src = 3'b100;
        in_imm = 32'hABCD_E000;
        in_base = 32'h0000_0037;
        step();
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_loaded: got %b want 1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", out_valid); end
        checks++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin
            errors++; $display("FAIL mr_counts: got %h/%h want 0000/0000", enc_count, err_count);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mr_stale: got stale word want none"); end
    endtask

    task automatic test_saturation();
        int tx = 0;
        int rx = 0;
        do_reset();
        out_ready = 1'b1;
        in_src = 3'b111;
        in_base = 32'h0000_0013;
        in_imm = 32'h0;
        for (int cyc = 0; cyc < 60 && rx < 20; cyc++) begin
            in_valid = (tx < 20);
            #1;
            if (out_valid && out_ready) rx++;
            if (in_valid && in_ready) tx++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (enc_count !== 16'd20 || err_count !== 16'd20) begin
            errors++; $display("FAIL sat_wide: got %0d/%0d want 20/20", enc_count, err_count);
        end
        checks++; if (sat_enc_count !== 4'hF || sat_err_count !== 4'hF) begin
            errors++; $display("FAIL sat_hold: got %h/%h want f/f", sat_enc_count, sat_err_count);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_backpressure();
        test_midstream_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
